rf_write_buffer: RTL and testbench
==================================

# rf_write_buffer

Posted-write queue that sits in front of the register file write port and acts as its writer. Producers (writeback stage, multi-cycle units) push register updates without waiting on the port. The buffer drains them in order, one per cycle, onto WEN/wsel/wdat. It also forwards still-pending data to readers, so a read of a queued register returns the youngest value, not the stale register file contents.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16.
- CLK  in  1  clock; state updates on posedge.
- nRST  in  1  reset; asynchronous, active-low.
- push  in  1  write request from a producer.
- push_sel  in  5  destination register.
- push_dat  in  32  write data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupied entries.
- ovf  out  1  one-cycle pulse: a push was dropped.
- drain_en  in  1  register file port available this cycle.
- WEN  out  1  register file write enable.
- wsel  out  5  register file write select.
- wdat  out  32  register file write data.
- rsel1, rsel2  in  5 each  reader selects, mirrored from register file read ports.
- byp_hit1, byp_hit2  out  1 each  a pending entry matches rselN.
- byp_dat1, byp_dat2  out  32 each  youngest matching pending data.

## Operation
- Circular FIFO with head pointer, tail pointer and count.
- pop = WEN. WEN = !empty && drain_en. wsel and wdat are the head entry, 0 when empty.
- Push accept rule: push && push_sel != 0 && (!full || pop).
- Push with push_sel == 0 is consumed silently. It is not enqueued and does not raise ovf.
- Push refused because the queue is full and not popping: entry dropped, ovf = 1 in the following cycle.
- Simultaneous push and pop: count unchanged. With count == 1, the new entry becomes head after the edge.
- Ordering is strict FIFO. Multiple entries for the same register are all kept and drained in order; no coalescing.
- Bypass search runs over all valid entries, including the head being drained this cycle, from tail-1 back to head.
  - The first match wins, so the youngest entry is returned.
  - rselN == 0 never hits.
  - Miss: byp_hitN = 0, byp_datN = 0.
  - The current-cycle push input is not searched.
- Reset: head = tail = count = 0, empty = 1, full = 0, WEN = 0, wsel = 0, wdat = 0, ovf = 0, byp_hit* = 0, byp_dat* = 0. Entry storage is cleared to 0.
- Reset mid-operation discards all pending writes; nothing is written to the register file.

## Timing
- Cycle k is the interval after posedge k.
- A push sampled at posedge k is in the queue during cycle k.
- If the queue was otherwise empty and drain_en = 1:
  - WEN is high during cycle k.
  - The register file captures the write on the negedge inside cycle k.
  - The entry is popped at posedge k+1.
- Enqueue-to-register-file latency is therefore one half cycle when empty, plus one cycle per older entry ahead of it.
- Bypass outputs are combinational from the stored entries and rselN. They are valid in cycle k for an entry pushed at posedge k, and cleared after its pop at posedge k+1.
- The register file holds the value from the negedge onward, so reads never see a gap.
- full, empty and count are registered-state decodes, stable for the whole cycle.
- ovf is registered: it is high exactly during cycle k+1 for a drop at posedge k+1.

## Configuration
- RF_WB_BYPASS_EN defined: bypass search logic is built as described.
- Undefined:
  - byp_hit1 and byp_hit2 are tied 0; byp_dat1 and byp_dat2 are tied 0.
  - No match logic is generated.
  - The hazard unit must stall reads while !empty.

## Structure
- cpu_types_pkg already provides word_t (32 bits) and regbits_t (5 bits).
- Add wb_entry_t to cpu_types_pkg: packed struct {regbits_t sel; word_t dat;}.
- Add constant WB_DEPTH_DEFAULT = 4 to cpu_types_pkg.
- One sub-module, rf_bypass_match: takes the entry array, valid mask, head and tail pointers and one rsel; returns hit and dat.
  - Instantiated twice, once per read port.
  - Compiled only under RF_WB_BYPASS_EN.

## Test plan
- Reset, then push sel=5, dat=0xDEADBEEF with drain_en=1 -> WEN=1, wsel=5, wdat=0xDEADBEEF in the same cycle; empty=1 after the next posedge; register 5 reads 0xDEADBEEF.
- drain_en=0, push sel=3 dat=1 then sel=3 dat=2, rsel1=3 -> byp_hit1=1, byp_dat1=2. drain_en=1 -> writes drain 1 then 2 in consecutive cycles; hit drops after the second pop.
- drain_en=0, DEPTH=4, five pushes -> full=1 after the fourth; the fifth is dropped with ovf=1 for one cycle; count stays 4.
- Full queue with drain_en=1 and push in the same cycle -> push accepted, count stays 4, ovf=0, drain order preserved.
- Push sel=0 dat=0x1234 -> count unchanged, WEN=0, ovf=0; rsel2=0 -> byp_hit2=0.
- Three entries queued, assert nRST low mid-cycle -> immediately empty=1, WEN=0, count=0; no register file write occurs.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the write-buffer entry format.
// rf_write_buffer's bypass path is built only when RF_WB_BYPASS_EN is defined.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } wb_entry_t;

  localparam int WB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/rf_bypass_match.sv
// Youngest-first search of pending write-buffer entries for one read port.
// Compiled only when RF_WB_BYPASS_EN is defined.
`ifdef RF_WB_BYPASS_EN
module rf_bypass_match
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry_t        i_ent [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  logic [PW-1:0]    i_head,
  input  logic [PW-1:0]    i_tail,
  input  regbits_t         i_rsel,
  output logic             o_hit,
  output word_t            o_dat
);

  logic  w_hit;
  word_t w_dat;

  // Walk from tail-1 back to head; the first valid match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    logic          done;
    w_hit = 1'b0;
    w_dat = '0;
    done  = 1'b0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_tail - PW'(k + 1);
      if (!done && i_valid[idx] && (i_rsel != '0) && (i_ent[idx].sel == i_rsel)) begin
        w_hit = 1'b1;
        w_dat = i_ent[idx].dat;
        done  = 1'b1;
      end
      if (idx == i_head) done = 1'b1;
    end
  end

  assign o_hit = w_hit;
  assign o_dat = w_dat;

endmodule
`endif

// File: rtl/rf_write_buffer.sv
// Posted-write FIFO driving the register file write port, with optional
// read bypass of pending entries (enabled by defining RF_WB_BYPASS_EN).
module rf_write_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          push,
  input  regbits_t      push_sel,
  input  word_t         push_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          ovf,
  input  logic          drain_en,
  output logic          WEN,
  output regbits_t      wsel,
  output word_t         wdat,
  input  regbits_t      rsel1,
  input  regbits_t      rsel2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output word_t         byp_dat1,
  output word_t         byp_dat2
);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_empty, w_full, w_pop, w_accept, w_drop, w_valid_push;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = !w_empty && drain_en;
  // Register 0 pushes are swallowed: never queued, never counted as a drop.
  assign w_valid_push = push && (push_sel != '0);
  assign w_accept     = w_valid_push && (!w_full || w_pop);
  assign w_drop       = w_valid_push && w_full && !w_pop;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_accept) begin
        r_mem[r_tail] <= '{sel: push_sel, dat: push_dat};
        r_tail        <= r_tail + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf <= w_drop;
    end
  end

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign WEN   = w_pop;
  assign wsel  = w_empty ? '0 : r_mem[r_head].sel;
  assign wdat  = w_empty ? '0 : r_mem[r_head].dat;

`ifdef RF_WB_BYPASS_EN
  logic [DEPTH-1:0] w_valid;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - r_head;
      w_valid[i] = ({1'b0, off} < r_count);
    end
  end

  rf_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .i_ent   (r_mem),
    .i_valid (w_valid),
    .i_head  (r_head),
    .i_tail  (r_tail),
    .i_rsel  (rsel1),
    .o_hit   (byp_hit1),
    .o_dat   (byp_dat1)
  );

  rf_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .i_ent   (r_mem),
    .i_valid (w_valid),
    .i_head  (r_head),
    .i_tail  (r_tail),
    .i_rsel  (rsel2),
    .o_hit   (byp_hit2),
    .o_dat   (byp_dat2)
  );
`else
  logic w_unused;
  assign w_unused = ^{rsel1, rsel2};
  assign byp_hit1 = 1'b0;
  assign byp_hit2 = 1'b0;
  assign byp_dat1 = '0;
  assign byp_dat2 = '0;
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer with a negedge-capturing register file model.
// Bypass expectations follow RF_WB_BYPASS_EN (zero when it is undefined).
module tb_rf_write_buffer;
  import cpu_types_pkg::*;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  logic push;
  regbits_t push_sel;
  word_t push_dat;
  logic full, empty, ovf, drain_en, WEN;
  logic [2:0] count;
  regbits_t wsel, rsel1, rsel2;
  word_t wdat, byp_dat1, byp_dat2;
  logic byp_hit1, byp_hit2;

  int vectors = 0;
  int miscompares = 0;
  word_t rf [32];
  int nwr = 0;
  int nwr_snap;

  rf_write_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .push(push), .push_sel(push_sel), .push_dat(push_dat),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .drain_en(drain_en),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel1(rsel1), .rsel2(rsel2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_dat1(byp_dat1), .byp_dat2(byp_dat2)
  );

  always #5 CLK = ~CLK;

  // Register file model: captures on the negedge inside the write cycle.
  always @(negedge CLK) begin
    if (WEN) begin
      rf[wsel] = wdat;
      nwr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_push(input logic [4:0] s, input logic [31:0] d);
    push = 1'b1; push_sel = s; push_dat = d;
    tick();
    push = 1'b0; push_sel = '0; push_dat = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    nRST = 1'b0; push = 1'b0; push_sel = '0; push_dat = '0;
    drain_en = 1'b0; rsel1 = '0; rsel2 = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_wen", WEN, 0);
    check("rst_wsel", wsel, 0);
    check("rst_wdat", wdat, 0);
    check("rst_ovf", ovf, 0);
    check("rst_hit1", byp_hit1, 0);
    #2 nRST = 1'b1;

    // Single push drains in its own cycle
    drain_en = 1'b1; rsel1 = 5'd5;
    do_push(5'd5, 32'hDEADBEEF);
    check("t1_wen", WEN, 1);
    check("t1_wsel", wsel, 5);
    check("t1_wdat", wdat, 32'hDEADBEEF);
    check("t1_count", count, 1);
    check("t1_hit1", byp_hit1, BYP);
    check("t1_dat1", byp_dat1, BYP ? 32'hDEADBEEF : 32'h0);
    @(negedge CLK); #1;
    check("t1_rf5", rf[5], 32'hDEADBEEF);
    tick();
    check("t1_empty", empty, 1);
    check("t1_wen_off", WEN, 0);
    check("t1_hit1_off", byp_hit1, 0);

    // Two writes to r3, youngest forwarded, drained in order
    drain_en = 1'b0; rsel1 = 5'd3;
    do_push(5'd3, 32'd1);
    do_push(5'd3, 32'd2);
    check("t2_count", count, 2);
    check("t2_wen", WEN, 0);
    check("t2_hit1", byp_hit1, BYP);
    check("t2_dat1", byp_dat1, BYP ? 32'd2 : 32'd0);
    drain_en = 1'b1; #1;
    check("t2_wen1", WEN, 1);
    check("t2_wdat1", wdat, 1);
    tick();
    check("t2_wdat2", wdat, 2);
    check("t2_hit1_b", byp_hit1, BYP);
    check("t2_dat1_b", byp_dat1, BYP ? 32'd2 : 32'd0);
    tick();
    check("t2_empty", empty, 1);
    check("t2_hit1_off", byp_hit1, 0);
    check("t2_dat1_off", byp_dat1, 0);
    check("t2_rf3", rf[3], 2);

    // Overflow on the fifth push
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) do_push(5'(10 + i), 32'hA0 + i);
    check("t3_full", full, 1);
    check("t3_count4", count, 4);
    check("t3_ovf0", ovf, 0);
    do_push(5'd14, 32'hA4);
    check("t3_ovf1", ovf, 1);
    check("t3_count_hold", count, 4);
    tick();
    check("t3_ovf_clr", ovf, 0);

    // Push while full and draining
    drain_en = 1'b1; #1;
    check("t4_wsel0", wsel, 10);
    do_push(5'd15, 32'hB0);
    check("t4_count", count, 4);
    check("t4_ovf", ovf, 0);
    check("t4_wsel1", wsel, 11);
    tick();
    check("t4_wsel2", wsel, 12);
    tick();
    check("t4_wsel3", wsel, 13);
    tick();
    check("t4_wsel4", wsel, 15);
    check("t4_wdat4", wdat, 32'hB0);
    tick();
    check("t4_empty", empty, 1);
    check("t4_rf13", rf[13], 32'hA3);
    check("t4_rf14", rf[14], 0);

    // Register 0 push is swallowed
    rsel2 = 5'd0;
    do_push(5'd0, 32'h1234);
    check("t5_count", count, 0);
    check("t5_wen", WEN, 0);
    check("t5_ovf", ovf, 0);
    check("t5_hit2", byp_hit2, 0);

    // Mid-cycle reset discards pending writes
    drain_en = 1'b0;
    do_push(5'd7, 32'h77);
    do_push(5'd8, 32'h88);
    do_push(5'd9, 32'h99);
    check("t6_count3", count, 3);
    nwr_snap = nwr;
    #1 nRST = 1'b0;
    drain_en = 1'b1;
    #1;
    check("t6_empty", empty, 1);
    check("t6_wen", WEN, 0);
    check("t6_count", count, 0);
    tick();
    #2 nRST = 1'b1;
    @(negedge CLK); #1;
    check("t6_nowrite", nwr - nwr_snap, 0);
    check("t6_rf7", rf[7], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
